// File: rtl/ram_io_responder_pkg.sv
// Shared constants for the memory/I-O responder.
//   BUS_W      : width of the byte bus and of every FIFO entry
//   IO_SEL     : value of mem_a[17:16] that selects the I/O window
//   OFF_DATA   : I/O offset of the console DATA register
//   OFF_STATUS : I/O offset of the STATUS register
//   ST_*       : bit positions inside the STATUS byte
package ram_io_responder_pkg;
  localparam int         BUS_W      = 8;
  localparam logic [1:0] IO_SEL     = 2'b11;
  localparam logic [2:0] OFF_DATA   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam int         ST_RXNE    = 0;
  localparam int         ST_TXF     = 1;
  localparam int         ST_OVF     = 2;
endpackage

// File: rtl/ram_io_responder_fifo.sv
// byte_fifo: synchronous byte FIFO with count-based full/empty.
// Ports:
//   clk, rst     : clock, synchronous active-low reset (clears pointers/count)
//   push, din    : write request and data
//   pop          : read request; dout always shows the head entry
//   full, empty  : combinational status from the occupancy count
// A push while full succeeds only if a pop happens in the same cycle; a pop
// while empty is ignored, so a simultaneous push/pop on empty only pushes.
module byte_fifo
  import ram_io_responder_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [BUS_W-1:0] din,
  input  logic             pop,
  output logic [BUS_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [BUS_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == (PW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_pop_ok  = pop & ~empty;
  // The pop frees the slot the push needs when the FIFO is full.
  assign w_push_ok = push & (~full | w_pop_ok);
  assign dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ram_io_responder.sv
// ram_io_responder: memory-side end of the 8-bit external memory bus.
// Serves byte reads/writes to an inferred block RAM and to an I/O window
// (mem_a[17:16] == 2'b11) holding a console TX FIFO and an RX FIFO.
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   mem_a, mem_dout       : byte address / write data from the controller
//   mem_wr                : 1 = write, 0 = read; every cycle is a transaction
//   mem_din               : registered read data (one-cycle latency)
//   io_full               : TX FIFO full (combinational)
//   tx_data/valid/ready   : console output stream
//   rx_data/valid/ready   : console input stream
// Handshakes: a byte moves on a rising edge where valid & ready are both 1;
// valid never depends on ready, and rx_ready is held low during reset.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int          RAM_AW     = 17,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] IO_BASE    = {14'd0, IO_SEL, 16'h0000}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      mem_a,
  input  logic [BUS_W-1:0] mem_dout,
  input  logic             mem_wr,
  output logic [BUS_W-1:0] mem_din,
  output logic             io_full,
  output logic [BUS_W-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [BUS_W-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready
);
  logic [BUS_W-1:0]  r_ram [2**RAM_AW];
  logic [BUS_W-1:0]  r_ram_q;
  logic [BUS_W-1:0]  r_io_q;
  logic              r_src_ram;
  logic              r_ovf;

  logic              w_io_sel;
  logic [2:0]        w_off;
  logic [RAM_AW-1:0] w_ram_addr;
  logic              w_tx_wr, w_st_wr, w_rx_rd;
  logic              w_tx_full, w_tx_empty, w_tx_pop;
  logic              w_rx_full, w_rx_empty, w_rx_push;
  logic [BUS_W-1:0]  w_rx_dout;
  logic [BUS_W-1:0]  w_status;
  logic              w_unused;

  assign w_io_sel   = (mem_a[17:16] == IO_BASE[17:16]);
  assign w_off      = mem_a[2:0];
  assign w_ram_addr = mem_a[RAM_AW-1:0];
  assign w_unused   = ^mem_a[31:18];

  assign w_tx_wr  = mem_wr & w_io_sel & (w_off == OFF_DATA);
  assign w_st_wr  = mem_wr & w_io_sel & (w_off == OFF_STATUS);
  assign w_rx_rd  = ~mem_wr & w_io_sel & (w_off == OFF_DATA);

  assign w_tx_pop  = tx_valid & tx_ready;
  assign tx_valid  = ~w_tx_empty;
  assign io_full   = w_tx_full;
  assign rx_ready  = rst & ~w_rx_full;
  assign w_rx_push = rx_valid & rx_ready;

  // Status reflects state before this edge's pushes/pops.
  always_comb begin
    w_status          = '0;
    w_status[ST_RXNE] = ~w_rx_empty;
    w_status[ST_TXF]  = w_tx_full;
    w_status[ST_OVF]  = r_ovf;
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .push(w_tx_wr), .din(mem_dout), .pop(w_tx_pop),
    .dout(tx_data), .full(w_tx_full), .empty(w_tx_empty)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .push(w_rx_push), .din(rx_data), .pop(w_rx_rd),
    .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty)
  );

  // Plain synchronous-read RAM with no reset so it maps onto block RAM;
  // the reset-able source select below masks its output instead.
  always_ff @(posedge clk) begin
    if (mem_wr & ~w_io_sel) r_ram[w_ram_addr] <= mem_dout;
    r_ram_q <= r_ram[w_ram_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_src_ram <= 1'b0;
      r_io_q    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_src_ram <= ~mem_wr & ~w_io_sel;
      r_io_q    <= '0;
      if (~mem_wr & w_io_sel) begin
        case (w_off)
          OFF_DATA:   r_io_q <= w_rx_empty ? '0 : w_rx_dout;
          OFF_STATUS: r_io_q <= w_status;
          default:    r_io_q <= '0;
        endcase
      end
      // A DATA write into a full TX FIFO is dropped unless a drain frees a slot.
      if (w_tx_wr & w_tx_full & ~w_tx_pop) r_ovf <= 1'b1;
      else if (w_st_wr)                    r_ovf <= 1'b0;
    end
  end

  assign mem_din = r_src_ram ? r_ram_q : r_io_q;
endmodule

// File: tb/tb_ram_io_responder.sv
module tb_ram_io_responder;
  localparam int DEPTH = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  always #5 clk = ~clk;

  ram_io_responder #(.RAM_AW(17), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din), .io_full(io_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  // ---------------- reference model / scoreboard ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_ram [int];
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic       m_ovf = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one bus transaction, advances the model, and checks the DUT
  // before the edge (state outputs) and after it (read data).
  task automatic cycle(input logic [31:0] a, input logic [7:0] d, input logic w,
                       input logic txr, input logic rxv, input logic [7:0] rxd);
    logic       io;
    logic [2:0] off;
    int         idx;
    logic       txfull, txpop, rxpush, rxpop, txpush, do_chk;
    logic [7:0] rd;
    mem_a = a; mem_dout = d; mem_wr = w; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    #1;
    check("tx_valid", tx_valid, m_tx.size() > 0);
    check("io_full", io_full, m_tx.size() == DEPTH);
    check("rx_ready", rx_ready, m_rx.size() < DEPTH);
    if (m_tx.size() > 0) check("tx_data", tx_data, m_tx[0]);
    io     = (a[17:16] == 2'b11);
    off    = a[2:0];
    idx    = int'(a[16:0]);
    txfull = (m_tx.size() == DEPTH);
    txpop  = (m_tx.size() > 0) && txr;
    rxpush = rxv && (m_rx.size() < DEPTH);
    rxpop  = 1'b0;
    txpush = 1'b0;
    do_chk = 1'b1;
    rd     = 8'h00;
    if (!w) begin
      if (!io) begin
        if (m_ram.exists(idx)) rd = m_ram[idx];
        else do_chk = 1'b0;
      end else if (off == 3'd0) begin
        if (m_rx.size() > 0) begin rd = m_rx[0]; rxpop = 1'b1; end
      end else if (off == 3'd4) begin
        rd = {5'b0, m_ovf, txfull, m_rx.size() > 0};
      end
      exp_q.push_back(rd);
    end else begin
      if (!io) m_ram[idx] = d;
      else if (off == 3'd0) begin
        if (txfull && !txpop) m_ovf = 1'b1;
        else txpush = 1'b1;
      end else if (off == 3'd4) m_ovf = 1'b0;
    end
    if (txpop)  void'(m_tx.pop_front());
    if (txpush) m_tx.push_back(d);
    if (rxpop)  void'(m_rx.pop_front());
    if (rxpush) m_rx.push_back(rxd);
    @(posedge clk); #1;
    if (!w) begin
      rd = exp_q.pop_front();
      if (do_chk) check("rd_data", mem_din, rd);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0; mem_a = 32'h10; mem_wr = 1'b0; mem_dout = 8'h00;
    tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h33;
    repeat (n) begin
      @(posedge clk); #1;
      check("rst_mem_din", mem_din, 8'h00);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_io_full", io_full, 1'b0);
      check("rst_rx_ready", rx_ready, 1'b0);
    end
    m_tx.delete(); m_rx.delete(); m_ovf = 1'b0; exp_q.delete();
    rst = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] a;   logic [7:0] d;  logic w;
    logic txr;        logic rxv;      logic [7:0] rxd;
    logic chk_din;    logic [7:0] exp_din;
    logic exp_txv;    logic [7:0] exp_txd;
  } vec_t;
  vec_t vecs[14];

  initial begin
    logic [7:0] drained[$];
    logic [31:0] a;
    int k;

    vecs[0]  = '{32'h0,     8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{32'h10,    8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{32'h10,    8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 8'h00};
    vecs[3]  = '{32'h30000, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h41};
    vecs[4]  = '{32'h30000, 8'h42, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h41};
    vecs[5]  = '{32'h30000, 8'h43, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h41};
    vecs[6]  = '{32'h0,     8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h42};
    vecs[7]  = '{32'h0,     8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h43};
    vecs[8]  = '{32'h0,     8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[9]  = '{32'h0,     8'h00, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[10] = '{32'h30004, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[11] = '{32'h30000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h7E, 1'b0, 8'h00};
    vecs[12] = '{32'h30000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[13] = '{32'h30004, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};

    do_reset(2);

    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].a, vecs[i].d, vecs[i].w, vecs[i].txr, vecs[i].rxv, vecs[i].rxd);
      if (vecs[i].chk_din) check($sformatf("vec%0d_din", i), mem_din, vecs[i].exp_din);
      check($sformatf("vec%0d_txv", i), tx_valid, vecs[i].exp_txv);
      if (vecs[i].exp_txv) check($sformatf("vec%0d_txd", i), tx_data, vecs[i].exp_txd);
    end

    // TX fill to full, overflow, status clear
    for (int i = 0; i < 16; i++) begin
      cycle(32'h30000, 8'h80 + 8'(i), 1'b1, 1'b0, 1'b0, 8'h00);
      if (i == 14) check("full_after_15", io_full, 1'b0);
      if (i == 15) check("full_after_16", io_full, 1'b1);
    end
    cycle(32'h30000, 8'hEE, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(32'h30004, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("status_ovf", mem_din, 8'h06);
    cycle(32'h30004, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(32'h30004, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("status_cleared", mem_din, 8'h02);

    // push and drain together while full
    cycle(32'h30000, 8'h99, 1'b1, 1'b1, 1'b0, 8'h00);
    check("simul_full", io_full, 1'b1);
    check("simul_head", tx_data, 8'h81);
    cycle(32'h30004, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("simul_no_ovf", mem_din, 8'h02);
    for (int i = 0; i < 16; i++) begin
      if (tx_valid) drained.push_back(tx_data);
      cycle(32'h0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    end
    check("drain_count", drained.size(), 16);
    if (drained.size() == 16) begin
      check("drain_first", drained[0], 8'h81);
      check("drain_last", drained[15], 8'h99);
    end
    check("drain_empty", tx_valid, 1'b0);

    // RX fill past full, then empty it
    for (int i = 0; i < 18; i++) cycle(32'h0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC0 + 8'(i));
    check("rx_full_ready", rx_ready, 1'b0);
    for (int i = 0; i < 17; i++) cycle(32'h30000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rx_drained", mem_din, 8'h00);

    // reset mid-operation
    for (int i = 0; i < 5; i++) cycle(32'h30000, 8'h50 + 8'(i), 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(32'h0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h60 + 8'(i));
    do_reset(1);
    cycle(32'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    check("ram_kept", mem_din, 8'hA5);
    check("rx_empty_after_rst", rx_ready, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 8; i++) cycle(32'h20 + 32'(i), 8'($urandom), 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 800; i++) begin
      k = $urandom_range(0, 10);
      if (k < 8)       a = {14'($urandom), 1'($urandom), 17'h20 + 17'(k)};
      else if (k == 8) a = {14'($urandom), 18'h30000};
      else if (k == 9) a = {14'($urandom), 18'h30004};
      else             a = {14'($urandom), 15'h6000, 3'($urandom_range(1, 7))};
      cycle(a, 8'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
            1'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
